adc_capture_ctrl: RTL and testbench

Capture/readout controller sitting directly upstream of the single-port sample RAM (ADDR_WIDTH=11, DATA_WIDTH=32, registered read address, read returns new data).

- **Capture:** on command, writes a programmed number of ADC samples into consecutive RAM addresses starting at 0.
- **Readout:** on a second command, streams the captured samples back out in address order, one per cycle.
- **RAM port:** the block is the only master of the RAM and accounts for its one-cycle read latency.

---
 rtl/adc_capture_ctrl.sv | 168 ++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: capture controller in front of a single-port sample RAM.
// A capture writes `len` ADC samples (0 means full depth) to addresses
// 0..len-1; a readout streams them back in address order, one per cycle,
// absorbing the RAM's one-cycle registered-read latency.
module adc_capture_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int ADC_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [ADC_WIDTH-1:0]  adc_data,
  input  logic                  adc_valid,
  input  logic                  rd_start,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  cap_done,
  output logic                  rd_done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READ    = 2'd2
  } state_t;

  // Full RAM depth expressed in the (ADDR_WIDTH+1)-bit count domain.
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH:0]     count_reg, count_next;
  logic [ADDR_WIDTH:0]     target_reg, target_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic                    we_reg, we_next;
  logic                    out_valid_reg, out_valid_next;
  logic                    cap_done_reg, cap_done_next;
  logic                    rd_done_reg, rd_done_next;
  // High while ram_addr carries a read address the RAM will sample.
  logic                    rd_issue_reg, rd_issue_next;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and next-output decode for capture and readout.
  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    target_next    = target_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    we_next        = 1'b0;
    out_valid_next = 1'b0;
    cap_done_next  = 1'b0;
    rd_done_next   = 1'b0;
    rd_issue_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // start takes priority over rd_start; an empty RAM ignores rd_start.
        if (start) begin
          state_next  = ST_CAPTURE;
          target_next = (len == '0) ? DEPTH : {1'b0, len};
          wr_ptr_next = '0;
          count_next  = '0;
        end else if (rd_start && (count_reg != '0)) begin
          state_next    = ST_READ;
          addr_next     = '0;
          rd_ptr_next   = ADDR_WIDTH'(1);
          rd_issue_next = 1'b1;
        end
      end

      ST_CAPTURE: begin
        if (adc_valid) begin
          we_next                   = 1'b1;
          addr_next                 = wr_ptr_reg;
          data_next                 = '0;
          data_next[ADC_WIDTH-1:0]  = adc_data;
          wr_ptr_next               = wr_ptr_reg + ADDR_WIDTH'(1);
          count_next                = count_reg + (ADDR_WIDTH + 1)'(1);
          // Leave as the last write is registered so busy drops with it.
          if (count_next == target_reg) begin
            state_next    = ST_IDLE;
            cap_done_next = 1'b1;
          end
        end
      end

      ST_READ: begin
        if (rd_issue_reg) begin
          // Data for the address on the bus appears one cycle later.
          out_valid_next = 1'b1;
          if ({1'b0, addr_reg} == (count_reg - (ADDR_WIDTH + 1)'(1))) begin
            rd_done_next = 1'b1;
          end else begin
            addr_next     = rd_ptr_reg;
            rd_ptr_next   = rd_ptr_reg + ADDR_WIDTH'(1);
            rd_issue_next = 1'b1;
          end
        end else begin
          // Trailing cycle that presented the final sample and rd_done.
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered output state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      target_reg    <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      we_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
      cap_done_reg  <= 1'b0;
      rd_done_reg   <= 1'b0;
      rd_issue_reg  <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      target_reg    <= target_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      we_reg        <= we_next;
      out_valid_reg <= out_valid_next;
      cap_done_reg  <= cap_done_next;
      rd_done_reg   <= rd_done_next;
      rd_issue_reg  <= rd_issue_next;
    end
  end

  assign ram_addr  = addr_reg;
  assign ram_data  = data_reg;
  assign ram_we    = we_reg;
  assign out_data  = ram_q;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign cap_done  = cap_done_reg;
  assign rd_done   = rd_done_reg;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed bench with an external RAM model, a
// transaction-level expectation model and a per-cycle output compare.
module tb_adc_capture_ctrl;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int CW = 12;
  localparam int D  = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0;
  logic [CW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          rd_start = 1'b0;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          cap_done;
  logic          rd_done;

  int n_checks = 0;
  int n_fail   = 0;

  adc_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADC_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .adc_data(adc_data),
    .adc_valid(adc_valid), .rd_start(rd_start), .ram_data(ram_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .cap_done(cap_done), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  // Single-port sample RAM: registered address, write returns new data.
  logic [DW-1:0] mem [0:D-1];
  logic [DW-1:0] ram_q_r;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q_r <= ram_we ? ram_data : mem[ram_addr];
  end
  assign ram_q = ram_q_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- expectation model ----------------
  // mode: 0 idle, 1 capturing, 2 reading. Read timing is derived from the
  // number of edges since the accepted rd_start (k=1 is the first busy cycle).
  int mode = 0, m_count = 0, m_target = 0, m_wr = 0, rd_k = 0;
  int mem_model [0:D-1];
  bit exp_we = 0, exp_cap_done = 0, chk_addr = 0, exp_out_valid = 0;
  bit exp_rd_done = 0, exp_busy = 0;
  int exp_addr = 0, exp_data = 0, exp_out_data = 0;

  task automatic model_step();
    if (rst) begin
      mode = 0; m_count = 0;
      exp_we = 0; exp_cap_done = 0; chk_addr = 0;
      exp_out_valid = 0; exp_rd_done = 0; exp_busy = 0;
      return;
    end
    exp_we = 0; exp_cap_done = 0; chk_addr = 0; exp_out_valid = 0; exp_rd_done = 0;
    if (mode == 0) begin
      if (start) begin
        mode = 1; m_target = (len == 0) ? D : int'(len); m_wr = 0; m_count = 0;
      end else if (rd_start && m_count != 0) begin
        mode = 2; rd_k = 0;
      end
    end else if (mode == 1) begin
      if (adc_valid) begin
        exp_we = 1; exp_addr = m_wr; exp_data = int'(adc_data);
        mem_model[m_wr] = exp_data;
        m_wr++; m_count = m_wr;
        if (m_wr == m_target) begin mode = 0; exp_cap_done = 1; end
      end
    end
    if (mode == 2) begin
      rd_k++;
      if (rd_k > m_count + 1) begin
        mode = 0;
      end else begin
        if (rd_k <= m_count) begin chk_addr = 1; exp_addr = rd_k - 1; end
        if (rd_k >= 2) begin exp_out_valid = 1; exp_out_data = mem_model[rd_k - 2]; end
        exp_rd_done = (rd_k == m_count + 1);
      end
    end
    exp_busy = (mode != 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_data", ram_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cap_done", cap_done, 0);
      chk("rst_rd_done", rd_done, 0);
    end else begin
      chk("ram_we", ram_we, exp_we);
      chk("busy", busy, exp_busy);
      chk("cap_done", cap_done, exp_cap_done);
      chk("out_valid", out_valid, exp_out_valid);
      chk("rd_done", rd_done, exp_rd_done);
      if (exp_we) chk("ram_data", ram_data, exp_data);
      if (exp_we || chk_addr) chk("ram_addr", ram_addr, exp_addr);
      if (exp_out_valid) chk("out_data", out_data, exp_out_data);
    end
  end

  // ---------------- event monitor for literal checks ----------------
  int we_cnt = 0, cap_cnt = 0, rd_cnt = 0, busy_cnt = 0, last_wr_addr = -1;
  logic [DW-1:0] out_log [$];

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (ram_we) begin we_cnt++; last_wr_addr = int'(ram_addr); end
      if (cap_done) cap_cnt++;
      if (rd_done) rd_cnt++;
      if (busy) busy_cnt++;
      if (out_valid) out_log.push_back(out_data);
    end
  end

  task automatic clear_counts();
    we_cnt = 0; cap_cnt = 0; rd_cnt = 0; busy_cnt = 0; last_wr_addr = -1;
    out_log.delete();
  endtask

  // One cycle of stimulus; inputs change 2 time units after the edge.
  task automatic drive(input logic s, input logic r, input logic [AW-1:0] l,
                       input logic v, input logic [CW-1:0] d);
    start = s; rd_start = r; len = l; adc_valid = v; adc_data = d;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_log(input string name, input logic [DW-1:0] exp_q [$]);
    chk({name, "_len"}, out_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
      chk(name, out_log[i], exp_q[i]);
  endtask

  initial begin
    int errs;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_we", ram_we, 0);

    // Readout request with nothing captured.
    $display("txn: rd_start on empty RAM");
    clear_counts();
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    idle(4);
    chk("empty_busy_cycles", busy_cnt, 0);
    chk("empty_out_valid", out_log.size(), 0);

    // Short capture with a gap, then readout.
    $display("txn: capture len=4");
    clear_counts();
    drive(1'b1, 1'b0, 11'd4, 1'b0, '0);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h001);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h002);
    drive(1'b0, 1'b0, '0, 1'b0, 12'h0ff);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h003);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h004);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h005);
    idle(2);
    chk("short_writes", we_cnt, 4);
    chk("short_last_addr", last_wr_addr, 3);
    chk("short_cap_done", cap_cnt, 1);
    $display("txn: readout count=4");
    clear_counts();
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    idle(8);
    check_log("short_read", '{32'd1, 32'd2, 32'd3, 32'd4});
    chk("short_rd_done", rd_cnt, 1);
    chk("short_busy_cycles", busy_cnt, 5);

    // Capture three samples, read twice.
    $display("txn: capture len=3, readout twice");
    drive(1'b1, 1'b0, 11'd3, 1'b0, '0);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h00a);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h00b);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h00c);
    idle(2);
    clear_counts();
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    idle(6);
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    idle(6);
    check_log("repeat_read", '{32'ha, 32'hb, 32'hc, 32'ha, 32'hb, 32'hc});
    chk("repeat_rd_done", rd_cnt, 2);

    // Commands during a capture are ignored.
    $display("txn: capture len=5 with commands while busy");
    clear_counts();
    drive(1'b1, 1'b0, 11'd5, 1'b0, '0);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h001);
    drive(1'b1, 1'b1, 11'd2, 1'b1, 12'h002);
    drive(1'b0, 1'b1, '0, 1'b1, 12'h003);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h004);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h005);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h006);
    idle(4);
    chk("busy_cmd_writes", we_cnt, 5);
    chk("busy_cmd_cap_done", cap_cnt, 1);
    chk("busy_cmd_no_read", out_log.size(), 0);

    // start and rd_start together: capture wins.
    $display("txn: start+rd_start together, len=2");
    clear_counts();
    drive(1'b1, 1'b1, 11'd2, 1'b0, '0);
    chk("arb_busy", busy, 1);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h007);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h008);
    idle(3);
    chk("arb_writes", we_cnt, 2);
    chk("arb_no_read", out_log.size(), 0);

    // Reset in the middle of a capture.
    $display("txn: capture len=8 interrupted by reset");
    drive(1'b1, 1'b0, 11'd8, 1'b0, '0);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h011);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h012);
    drive(1'b0, 1'b0, '0, 1'b1, 12'h013);
    rst = 1'b1;
    #1;
    chk("midrst_we", ram_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", ram_addr, 0);
    chk("midrst_data", ram_data, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    clear_counts();
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    idle(4);
    chk("midrst_rd_busy", busy_cnt, 0);
    chk("midrst_rd_valid", out_log.size(), 0);

    // Full-depth capture of a ramp and its readout.
    $display("txn: full-depth capture len=0");
    clear_counts();
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < D; i++) drive(1'b0, 1'b0, '0, 1'b1, CW'(i));
    idle(2);
    chk("full_writes", we_cnt, D);
    chk("full_last_addr", last_wr_addr, D - 1);
    chk("full_cap_done", cap_cnt, 1);
    $display("txn: full-depth readout count=%0d", D);
    clear_counts();
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    idle(D + 8);
    chk("full_out_cnt", out_log.size(), D);
    chk("full_rd_done", rd_cnt, 1);
    chk("full_busy_cycles", busy_cnt, D + 1);
    errs = 0;
    for (int i = 0; i < out_log.size(); i++)
      if (out_log[i] !== DW'(i)) errs++;
    chk("full_ramp_errs", errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
